// File: rtl/sd_sector_uart_dump.sv
// sd_sector_uart_dump: captures one 512-byte sector from the sector reader's
// byte stream and sends it as an uppercase ASCII hex dump over UART TX (8N1),
// 16 bytes per line, each line terminated with CR LF.
// Optional build macro SECTOR_DUMP_ADDR_EN prefixes every line with the
// 3-hex-digit offset of its first byte followed by ':' and a space.
module sd_sector_uart_dump #(
    parameter int unsigned UART_CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rvalid,
    input  logic [8:0] raddr,
    input  logic [7:0] rdata,
    input  logic       done,
    output logic       uart_tx,
    output logic       busy,
    output logic       overrun
);

    localparam logic [15:0] DIV_LAST = 16'(UART_CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef SECTOR_DUMP_ADDR_EN
        S_PFX,
`endif
        S_HI,
        S_LO,
        S_SEP,
        S_DRAIN
    } state_t;

    state_t      state, state_d;
    logic [8:0]  idx;
    logic        idx_clr, idx_inc;
    logic        sep_lf, sep_lf_d;
    logic        done_q;

    logic [7:0]  mem [0:511];
    logic [7:0]  rd_byte;

    logic        tx_active;
    logic [8:0]  tx_sh;
    logic [3:0]  bit_cnt;
    logic [15:0] div_cnt;
    logic        tx_ready, frame_end;
    logic        ch_valid, ch_take;
    logic [7:0]  ch_data;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign busy      = (state != S_IDLE);
    assign frame_end = tx_active && (div_cnt == DIV_LAST) && (bit_cnt == 4'd9);
    // The engine accepts a new char on the edge that ends the previous stop bit,
    // so characters leave back-to-back with no idle gap.
    assign tx_ready  = !tx_active || frame_end;
    assign ch_take   = ch_valid && tx_ready;

`ifdef SECTOR_DUMP_ADDR_EN
    logic [2:0] pfx_cnt;
    logic [7:0] pfx_char;

    // Select the prefix character: three offset digits, ':' and a space.
    always_comb begin
        pfx_char = 8'h20;
        case (pfx_cnt)
            3'd0:    pfx_char = hex_char({3'b000, idx[8]});
            3'd1:    pfx_char = hex_char(idx[7:4]);
            3'd2:    pfx_char = hex_char(idx[3:0]);
            3'd3:    pfx_char = 8'h3A;
            default: pfx_char = 8'h20;
        endcase
    end

    // Step through the five prefix characters as the engine takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfx_cnt <= '0;
        end else if (state == S_PFX && tx_ready) begin
            pfx_cnt <= (pfx_cnt == 3'd4) ? 3'd0 : pfx_cnt + 3'd1;
        end
    end
`endif

    // Sector buffer write while idle, and the one-cycle read of the current byte.
    always_ff @(posedge clk) begin
        if (rvalid && !busy) begin
            mem[raddr] <= rdata;
        end
        if (state == S_LOAD) begin
            rd_byte <= mem[idx];
        end
    end

    // Control registers: state, byte index, CR/LF phase, done edge detect, overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            sep_lf  <= 1'b0;
            // Starts high so a done level still present when reset releases
            // is not mistaken for a new rising edge.
            done_q  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            state  <= state_d;
            sep_lf <= sep_lf_d;
            done_q <= done;
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 9'd1;
            end
            if (rvalid && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Next-state logic and choice of the character offered to the UART engine.
    always_comb begin
        state_d  = state;
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        sep_lf_d = sep_lf;
        case (state)
            S_IDLE: begin
                if (done && !done_q) begin
                    state_d = S_LOAD;
                    idx_clr = 1'b1;
                end
            end
            S_LOAD: begin
`ifdef SECTOR_DUMP_ADDR_EN
                state_d = (idx[3:0] == 4'h0) ? S_PFX : S_HI;
`else
                state_d = S_HI;
`endif
            end
`ifdef SECTOR_DUMP_ADDR_EN
            S_PFX: begin
                ch_valid = 1'b1;
                ch_data  = pfx_char;
                if (tx_ready && pfx_cnt == 3'd4) begin
                    state_d = S_HI;
                end
            end
`endif
            S_HI: begin
                ch_valid = 1'b1;
                ch_data  = hex_char(rd_byte[7:4]);
                if (tx_ready) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                ch_valid = 1'b1;
                ch_data  = hex_char(rd_byte[3:0]);
                if (tx_ready) begin
                    state_d = S_SEP;
                end
            end
            S_SEP: begin
                ch_valid = 1'b1;
                if (idx[3:0] != 4'hF) begin
                    ch_data = 8'h20;
                    if (tx_ready) begin
                        idx_inc = 1'b1;
                        state_d = S_LOAD;
                    end
                end else if (!sep_lf) begin
                    ch_data = 8'h0D;
                    if (tx_ready) begin
                        sep_lf_d = 1'b1;
                    end
                end else begin
                    ch_data = 8'h0A;
                    if (tx_ready) begin
                        sep_lf_d = 1'b0;
                        if (idx == 9'd511) begin
                            state_d = S_DRAIN;
                        end else begin
                            idx_inc = 1'b1;
                            state_d = S_LOAD;
                        end
                    end
                end
            end
            // Final LF is on the wire; busy drops as its stop bit completes.
            S_DRAIN: begin
                if (frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // UART character engine: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_active <= 1'b0;
            uart_tx   <= 1'b1;
            tx_sh     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else if (ch_take) begin
            tx_active <= 1'b1;
            uart_tx   <= 1'b0;
            tx_sh     <= {1'b1, ch_data};
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else if (tx_active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    uart_tx <= tx_sh[0];
                    tx_sh   <= {1'b1, tx_sh[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_uart_dump.sv
// Testbench for sd_sector_uart_dump: decodes the UART stream and checks
// content, frame timing, overrun, retrigger rules and asynchronous reset.
`timescale 1ns/1ps
module tb_sd_sector_uart_dump;

    localparam int DIV = 2;
`ifdef SECTOR_DUMP_ADDR_EN
    localparam int LINE = 54;
    localparam int PFX  = 5;
`else
    localparam int LINE = 49;
    localparam int PFX  = 0;
`endif
    localparam int TOTAL = LINE * 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rvalid = 1'b0;
    logic [8:0] raddr = '0;
    logic [7:0] rdata = '0;
    logic       done = 1'b0;
    logic       uart_tx, busy, overrun;

    sd_sector_uart_dump #(.UART_CLK_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rvalid  (rvalid),
        .raddr   (raddr),
        .rdata   (rdata),
        .done    (done),
        .uart_tx (uart_tx),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // UART receiver, sampling each bit near its middle on the falling clock edge.
    logic [7:0] rx_q[$];
    int         frame_err = 0;
    int         last_start = 0;
    int         rx_phase = 0;
    int         rx_k = 0;
    logic       rx_on = 1'b0;
    logic [9:0] rx_bits = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on    = 1'b0;
            rx_phase = 0;
        end else begin
            if (!rx_on && uart_tx == 1'b0) begin
                rx_on      = 1'b1;
                rx_phase   = 0;
                last_start = cyc;
            end
            if (rx_on) begin
                rx_phase++;
                if (((rx_phase - DIV / 2) % DIV) == 0) begin
                    rx_k = (rx_phase - DIV / 2) / DIV;
                    rx_bits[rx_k] = uart_tx;
                    if (rx_k == 9) begin
                        rx_on = 1'b0;
                        if (rx_bits[0] != 1'b0 || rx_bits[9] != 1'b1) frame_err++;
                        rx_q.push_back(rx_bits[8:1]);
                    end
                end
            end
        end
    end

    // Reference formatter: byte n of the sector holds n[7:0], except byte 0.
    function automatic logic [7:0] exp_char(input int pos, input logic [7:0] first_byte);
        string      hx;
        int         line, c, b;
        logic [8:0] off;
        logic [7:0] d;
        hx   = "0123456789ABCDEF";
        line = pos / LINE;
        c    = pos % LINE;
        off  = 9'(line * 16);
        if (c < PFX) begin
            case (c)
                0:       return hx[{3'b000, off[8]}];
                1:       return hx[off[7:4]];
                2:       return hx[off[3:0]];
                3:       return 8'h3A;
                default: return 8'h20;
            endcase
        end
        c = c - PFX;
        if (c == 47) return 8'h0D;
        if (c == 48) return 8'h0A;
        b = line * 16 + c / 3;
        d = (b == 0) ? first_byte : 8'(b);
        case (c % 3)
            0:       return hx[d[7:4]];
            1:       return hx[d[3:0]];
            default: return 8'h20;
        endcase
    endfunction

    typedef struct {
        int         pos;
        logic [7:0] ch;
    } vec_t;

    vec_t       vt[$];
    int         ok, mm, t0;
    logic [7:0] c1, c2;
    logic [10:0] fr;

    initial begin
`ifdef SECTOR_DUMP_ADDR_EN
        vt.push_back('{0, 8'h30});    vt.push_back('{1, 8'h30});    vt.push_back('{2, 8'h30});
        vt.push_back('{3, 8'h3A});    vt.push_back('{4, 8'h20});    vt.push_back('{5, 8'h30});
        vt.push_back('{6, 8'h30});    vt.push_back('{7, 8'h20});    vt.push_back('{52, 8'h0D});
        vt.push_back('{53, 8'h0A});   vt.push_back('{54, 8'h30});   vt.push_back('{55, 8'h31});
        vt.push_back('{56, 8'h30});   vt.push_back('{57, 8'h3A});   vt.push_back('{58, 8'h20});
        vt.push_back('{59, 8'h31});   vt.push_back('{60, 8'h30});   vt.push_back('{1674, 8'h31});
        vt.push_back('{1675, 8'h46}); vt.push_back('{1676, 8'h30}); vt.push_back('{1677, 8'h3A});
        vt.push_back('{1678, 8'h20}); vt.push_back('{1679, 8'h46}); vt.push_back('{1680, 8'h30});
        vt.push_back('{1726, 8'h0D}); vt.push_back('{1727, 8'h0A});
        c1 = 8'h30; c2 = 8'h30;
`else
        vt.push_back('{0, 8'h30});    vt.push_back('{1, 8'h30});    vt.push_back('{2, 8'h20});
        vt.push_back('{3, 8'h30});    vt.push_back('{4, 8'h31});    vt.push_back('{44, 8'h20});
        vt.push_back('{45, 8'h30});   vt.push_back('{46, 8'h46});   vt.push_back('{47, 8'h0D});
        vt.push_back('{48, 8'h0A});   vt.push_back('{49, 8'h31});   vt.push_back('{50, 8'h30});
        vt.push_back('{51, 8'h20});   vt.push_back('{98, 8'h32});   vt.push_back('{99, 8'h30});
        vt.push_back('{1519, 8'h46}); vt.push_back('{1520, 8'h30}); vt.push_back('{1521, 8'h20});
        vt.push_back('{1564, 8'h46}); vt.push_back('{1565, 8'h46}); vt.push_back('{1566, 8'h0D});
        vt.push_back('{1567, 8'h0A});
        c1 = 8'h41; c2 = 8'h35;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk) rst_n = 1'b1;

        // Ramp sector: byte n = n[7:0]
        for (int n = 0; n < 512; n++) begin
            @(negedge clk);
            rvalid = 1'b1; raddr = 9'(n); rdata = 8'(n);
        end
        @(negedge clk) rvalid = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_before_done", int'(busy), 0);

        // Dump 1: trigger, overrun pulse, done toggles while busy
        rx_q.delete();
        t0 = cyc;
        done = 1'b1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy) begin ok = 1; break; end
        end
        check("busy_latency", cyc - t0, 1);
        t0 = cyc;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (uart_tx == 1'b0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("first_start_within_3", int'(ok == 1 && (cyc - t0) <= 3), 1);

        ok = 0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            if (i == 200) begin rvalid = 1'b1; raddr = 9'd0; rdata = 8'hFF; end
            if (i == 201) rvalid = 1'b0;
            if (i == 203) check("overrun_set", int'(overrun), 1);
            if (i == 300) done = 1'b0;
            if (i == 400) done = 1'b1;
            if (!busy) begin ok = 1; break; end
        end
        check("dump1_completes", ok, 1);
        check("busy_fall_after_stop", cyc - last_start, 10 * DIV);
        check("dump1_len", rx_q.size(), TOTAL);
        check("dump1_framing", frame_err, 0);
        check("overrun_sticky", int'(overrun), 1);
        mm = 0;
        for (int p = 0; p < rx_q.size() && p < TOTAL; p++)
            if (rx_q[p] !== exp_char(p, 8'h00)) mm++;
        check("dump1_stream", mm, 0);
        foreach (vt[v])
            check($sformatf("char_at_%0d", vt[v].pos),
                  (vt[v].pos < rx_q.size()) ? int'(rx_q[vt[v].pos]) : -1, int'(vt[v].ch));

        // Held done must not retrigger
        repeat (100) @(posedge clk);
        #1;
        check("no_retrigger_busy", int'(busy), 0);
        check("no_retrigger_chars", rx_q.size(), TOTAL);

        // Dump 2: buffer unchanged by dropped write, then reset mid-frame
        rx_q.delete();
        @(negedge clk) done = 1'b0;
        @(negedge clk) done = 1'b1;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (rx_q.size() >= 100) begin ok = 1; break; end
        end
        check("dump2_reaches_100", ok, 1);
        mm = 0;
        for (int p = 0; p < rx_q.size() && p < 100; p++)
            if (rx_q[p] !== exp_char(p, 8'h00)) mm++;
        check("dump2_first_100", mm, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (uart_tx == 1'b0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("dump2_frame_started", ok, 1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("async_rst_uart_tx", int'(uart_tx), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_overrun", int'(overrun), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("no_dump_without_edge", int'(busy), 0);

        // Dump 3: write and done edge in the same cycle; exact frame timing
        rx_q.delete();
        @(negedge clk) done = 1'b0;
        @(negedge clk);
        done = 1'b1; rvalid = 1'b1; raddr = 9'd0; rdata = 8'hA5;
        @(negedge clk) rvalid = 1'b0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (uart_tx == 1'b0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("dump3_started", ok, 1);
        fr = {1'b0, 1'b1, c1, 1'b0};
        for (int j = 0; j <= 10 * DIV; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            check($sformatf("frame_bit_%0d", j), int'(uart_tx), int'(fr[j / DIV]));
        end
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rx_q.size() >= 2) begin ok = 1; break; end
        end
        check("dump3_two_chars", ok, 1);
        check("dump3_char0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, int'(c1));
        check("dump3_char1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, int'(c2));
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
